// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, zero-delay data RAM between instruction fetch and
//   the load/store unit. Word-aligns every RAM address, extracts and extends
//   byte/half loads, and turns sub-word stores into a two-cycle
//   read-modify-write because the RAM only writes whole words.
//
// Ports
//   clock, reset           : clock, asynchronous active-low reset
//   iReq/iAddr             : fetch request, byte address (low 2 bits ignored)
//   iGnt                   : fetch granted this cycle (combinational)
//   iRValid/iRData         : fetched word, one cycle after grant
//   dReq/dWe/dSize/        : data request: store flag, size (00 b, 01 h,
//   dUnsigned/dAddr/dWData :   10 w, 11 illegal), zero-extend, addr, wdata
//   dGnt                   : data granted this cycle (combinational)
//   dRValid/dRData/dErr    : load data or store ack; dErr flags misaligned or
//                            illegal access
//   RAMAddr/RAMDataOut/    : RAM address (word aligned), write data and
//   RAMWriteControl        :   write enable
//   RAMOut                 : RAM combinational read data
module mem_port_arbiter #(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iReq,
  input  logic [RAMAddrSize-1:0] iAddr,
  output logic                   iGnt,
  output logic                   iRValid,
  output logic [dataW-1:0]       iRData,
  input  logic                   dReq,
  input  logic                   dWe,
  input  logic [1:0]             dSize,
  input  logic                   dUnsigned,
  input  logic [RAMAddrSize-1:0] dAddr,
  input  logic [dataW-1:0]       dWData,
  output logic                   dGnt,
  output logic                   dRValid,
  output logic [dataW-1:0]       dRData,
  output logic                   dErr,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       RAMDataOut,
  output logic                   RAMWriteControl,
  input  logic [dataW-1:0]       RAMOut
);

  localparam logic [RAMAddrSize-1:0] ALIGN_MASK = {{(RAMAddrSize-2){1'b1}}, 2'b00};

  typedef enum logic {IDLE, RMW_WR} state_t;

  // Everything the write half of a sub-word store needs, captured at grant.
  typedef struct packed {
    logic [RAMAddrSize-1:0] addr;
    logic [dataW-1:0]       word;
    logic [1:0]             lane;
    logic                   half;
    logic [15:0]            wdata;
  } rmw_t;

  state_t state, state_nxt;
  logic   lastWin, lastWin_nxt;   // 0 = fetch, 1 = data won last contest
  rmw_t   rmw;

  logic             d_err;
  logic             d_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [dataW-1:0] ld_data;
  logic [dataW-1:0] merged;

  assign d_word = (dSize == 2'b10);
  assign d_err  = (dSize == 2'b11) ||
                  (dSize == 2'b01 && dAddr[0]) ||
                  (dSize == 2'b10 && dAddr[1:0] != 2'b00);

  // Little-endian lane extraction and sign/zero extension for loads.
  always_comb begin
    ld_byte = RAMOut[7:0];
    case (dAddr[1:0])
      2'd0: ld_byte = RAMOut[7:0];
      2'd1: ld_byte = RAMOut[15:8];
      2'd2: ld_byte = RAMOut[23:16];
      2'd3: ld_byte = RAMOut[31:24];
      default: ld_byte = RAMOut[7:0];
    endcase
    ld_half = dAddr[1] ? RAMOut[31:16] : RAMOut[15:0];
    case (dSize)
      2'b00:   ld_data = {{(dataW-8){ld_byte[7] & ~dUnsigned}}, ld_byte};
      2'b01:   ld_data = {{(dataW-16){ld_half[15] & ~dUnsigned}}, ld_half};
      default: ld_data = RAMOut;
    endcase
  end

  // Old word with the target lane replaced by the store data.
  always_comb begin
    merged = rmw.word;
    if (rmw.half) begin
      if (rmw.lane[1]) merged[31:16] = rmw.wdata;
      else             merged[15:0]  = rmw.wdata;
    end else begin
      case (rmw.lane)
        2'd0: merged[7:0]   = rmw.wdata[7:0];
        2'd1: merged[15:8]  = rmw.wdata[7:0];
        2'd2: merged[23:16] = rmw.wdata[7:0];
        2'd3: merged[31:24] = rmw.wdata[7:0];
        default: merged = rmw.word;
      endcase
    end
  end

  // Arbitration and RAM drive. Reset gates everything so a reset asserted
  // during RMW_WR drops the write enable in that same cycle.
  always_comb begin
    iGnt            = 1'b0;
    dGnt            = 1'b0;
    RAMAddr         = '0;
    RAMDataOut      = '0;
    RAMWriteControl = 1'b0;
    state_nxt       = state;
    lastWin_nxt     = lastWin;
    if (reset) begin
      case (state)
        IDLE: begin
          if (iReq && dReq) begin
            dGnt        = ~lastWin;
            iGnt        = lastWin;
            lastWin_nxt = ~lastWin;
          end else begin
            iGnt = iReq;
            dGnt = dReq;
          end
          if (iGnt) begin
            RAMAddr = iAddr & ALIGN_MASK;
          end else if (dGnt) begin
            RAMAddr = dAddr & ALIGN_MASK;
            if (!d_err && dWe) begin
              if (d_word) begin
                RAMWriteControl = 1'b1;
                RAMDataOut      = dWData;
              end else begin
                state_nxt = RMW_WR;
              end
            end
          end
        end
        RMW_WR: begin
          RAMAddr         = rmw.addr;
          RAMDataOut      = merged;
          RAMWriteControl = 1'b1;
          state_nxt       = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lastWin <= 1'b0;
      iRValid <= 1'b0;
      iRData  <= '0;
      dRValid <= 1'b0;
      dRData  <= '0;
      dErr    <= 1'b0;
      rmw     <= '0;
    end else begin
      state   <= state_nxt;
      lastWin <= lastWin_nxt;
      iRValid <= iGnt;
      if (iGnt) iRData <= RAMOut;
      dRValid <= 1'b0;
      dErr    <= 1'b0;
      if (state == RMW_WR) begin
        dRValid <= 1'b1;
        dRData  <= '0;
      end else if (dGnt) begin
        if (d_err) begin
          dRValid <= 1'b1;
          dErr    <= 1'b1;
          dRData  <= '0;
        end else if (!dWe) begin
          dRValid <= 1'b1;
          dRData  <= ld_data;
        end else if (d_word) begin
          dRValid <= 1'b1;
          dRData  <= '0;
        end else begin
          // Sub-word store: read half done now, ack comes after RMW_WR.
          rmw.addr  <= dAddr & ALIGN_MASK;
          rmw.word  <= RAMOut;
          rmw.lane  <= dAddr[1:0];
          rmw.half  <= dSize[0];
          rmw.wdata <= dWData[15:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iGnt, iRValid;
  logic [31:0] iRData;
  logic        dReq, dWe, dUnsigned;
  logic [1:0]  dSize;
  logic [31:0] dAddr, dWData;
  logic        dGnt, dRValid, dErr;
  logic [31:0] dRData;
  logic [31:0] RAMAddr, RAMDataOut, RAMOut;
  logic        RAMWriteControl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.dataW(32), .RAMAddrSize(32)) dut (
    .clock(clock), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRValid(iRValid), .iRData(iRData),
    .dReq(dReq), .dWe(dWe), .dSize(dSize), .dUnsigned(dUnsigned), .dAddr(dAddr),
    .dWData(dWData), .dGnt(dGnt), .dRValid(dRValid), .dRData(dRData), .dErr(dErr),
    .RAMAddr(RAMAddr), .RAMDataOut(RAMDataOut), .RAMWriteControl(RAMWriteControl),
    .RAMOut(RAMOut)
  );

  // Zero-delay RAM model; words at 0x0-0x7 are write protected.
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  assign RAMOut = mem[RAMAddr[11:2]];
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr[11:2]] <= pre_data;
    else if (RAMWriteControl && RAMAddr >= 32'h8) mem[RAMAddr[11:2]] <= RAMDataOut;
  end

  localparam logic [31:0] LD_ADDR [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
  localparam logic [1:0]  LD_SIZE [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
  localparam logic        LD_UNS  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] LD_EXP  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic dset(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    dReq = 1'b1; dWe = we; dSize = sz; dUnsigned = uns; dAddr = a; dWData = wd;
  endtask

  initial begin
    reset = 1'b0;
    iReq = 1'b1; iAddr = 32'h200;
    dset(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
    #2;
    chk("rst_igngt", {31'b0, iGnt}, 32'h0);
    chk("rst_dgnt", {31'b0, dGnt}, 32'h0);
    chk("rst_we", {31'b0, RAMWriteControl}, 32'h0);
    chk("rst_addr", RAMAddr, 32'h0);
    chk("rst_irvalid", {31'b0, iRValid}, 32'h0);
    chk("rst_drvalid", {31'b0, dRValid}, 32'h0);
    chk("rst_derr", {31'b0, dErr}, 32'h0);
    chk("rst_irdata", iRData, 32'h0);
    chk("rst_drdata", dRData, 32'h0);
    iReq = 1'b0; dReq = 1'b0;
    preload(32'h104, 32'hCAFEF00D);
    reset = 1'b1;
    tick();
    chk("idle_addr", RAMAddr, 32'h0);
    chk("idle_dout", RAMDataOut, 32'h0);

    // Word store then word load
    dset(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    chk("sw_gnt", {31'b0, dGnt}, 32'h1);
    chk("sw_we", {31'b0, RAMWriteControl}, 32'h1);
    chk("sw_dout", RAMDataOut, 32'hDEADBEEF);
    chk("sw_addr", RAMAddr, 32'h100);
    tick(); dReq = 1'b0;
    chk("sw_ack", {31'b0, dRValid}, 32'h1);
    chk("sw_rdata", dRData, 32'h0);
    chk("sw_mem", mem[32'h100 >> 2], 32'hDEADBEEF);
    dset(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    chk("lw_gnt", {31'b0, dGnt}, 32'h1);
    chk("lw_we", {31'b0, RAMWriteControl}, 32'h0);
    tick(); dReq = 1'b0;
    chk("lw_vld", {31'b0, dRValid}, 32'h1);
    chk("lw_data", dRData, 32'hDEADBEEF);
    chk("lw_err", {31'b0, dErr}, 32'h0);

    // Byte / half loads with extension
    preload(32'h100, 32'h80FF7F01);
    for (int k = 0; k < 4; k++) begin
      dset(1'b0, LD_SIZE[k], LD_UNS[k], LD_ADDR[k], 32'h0);
      #1;
      chk($sformatf("ld%0d_gnt", k), {31'b0, dGnt}, 32'h1);
      chk($sformatf("ld%0d_addr", k), RAMAddr, 32'h100);
      tick(); dReq = 1'b0;
      chk($sformatf("ld%0d_vld", k), {31'b0, dRValid}, 32'h1);
      chk($sformatf("ld%0d_data", k), dRData, LD_EXP[k]);
    end

    // Sub-word read-modify-write
    preload(32'h200, 32'h11223344);
    dset(1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFFFFAA);
    #1;
    chk("sb_gnt", {31'b0, dGnt}, 32'h1);
    chk("sb_we0", {31'b0, RAMWriteControl}, 32'h0);
    chk("sb_addr0", RAMAddr, 32'h200);
    tick(); dReq = 1'b0; iReq = 1'b1; iAddr = 32'h200;
    chk("sb_novld", {31'b0, dRValid}, 32'h0);
    #1;
    chk("rmw_ignt", {31'b0, iGnt}, 32'h0);
    chk("rmw_dgnt", {31'b0, dGnt}, 32'h0);
    chk("rmw_we", {31'b0, RAMWriteControl}, 32'h1);
    chk("rmw_addr", RAMAddr, 32'h200);
    chk("rmw_dout", RAMDataOut, 32'h1122AA44);
    tick(); iReq = 1'b0;
    chk("sb_ack", {31'b0, dRValid}, 32'h1);
    chk("sb_rdata", dRData, 32'h0);
    chk("sb_mem", mem[32'h200 >> 2], 32'h1122AA44);
    dset(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF);
    #1;
    chk("sh_gnt", {31'b0, dGnt}, 32'h1);
    tick(); dReq = 1'b0;
    chk("sh_novld", {31'b0, dRValid}, 32'h0);
    chk("sh_dout", RAMDataOut, 32'hBEEFAA44);
    tick();
    chk("sh_ack", {31'b0, dRValid}, 32'h1);
    chk("sh_mem", mem[32'h200 >> 2], 32'hBEEFAA44);

    // Contested arbitration: D, I, D, I
    iReq = 1'b1; iAddr = 32'h202;
    dset(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arb%0d_dgnt", k), {31'b0, dGnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("arb%0d_ignt", k), {31'b0, iGnt}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk($sformatf("arb%0d_addr", k), RAMAddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      chk($sformatf("arb%0d_dvld", k), {31'b0, dRValid}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("arb%0d_ivld", k), {31'b0, iRValid}, (k % 2 == 0) ? 32'h0 : 32'h1);
      if (k % 2 == 0) chk($sformatf("arb%0d_ddata", k), dRData, 32'h80FF7F01);
      else            chk($sformatf("arb%0d_idata", k), iRData, 32'hBEEFAA44);
    end
    iReq = 1'b0; dReq = 1'b0;

    // Misaligned / illegal accesses
    dset(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    #1;
    chk("mlw_gnt", {31'b0, dGnt}, 32'h1);
    chk("mlw_we", {31'b0, RAMWriteControl}, 32'h0);
    tick(); dReq = 1'b0;
    chk("mlw_vld", {31'b0, dRValid}, 32'h1);
    chk("mlw_err", {31'b0, dErr}, 32'h1);
    chk("mlw_data", dRData, 32'h0);
    dset(1'b1, 2'b01, 1'b0, 32'h105, 32'h00001234);
    #1;
    chk("msh_gnt", {31'b0, dGnt}, 32'h1);
    chk("msh_we", {31'b0, RAMWriteControl}, 32'h0);
    tick(); dReq = 1'b0;
    chk("msh_vld", {31'b0, dRValid}, 32'h1);
    chk("msh_err", {31'b0, dErr}, 32'h1);
    chk("msh_data", dRData, 32'h0);
    #1;
    chk("msh_idle_we", {31'b0, RAMWriteControl}, 32'h0);
    tick();
    chk("msh_mem", mem[32'h104 >> 2], 32'hCAFEF00D);
    chk("msh_errclr", {31'b0, dErr}, 32'h0);

    // One contest so data is lastWin, then reset mid-RMW
    iReq = 1'b1; iAddr = 32'h200;
    dset(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    chk("pre_dgnt", {31'b0, dGnt}, 32'h1);
    tick(); iReq = 1'b0; dReq = 1'b0;
    preload(32'h100, 32'h12345678);
    dset(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000055);
    tick(); dReq = 1'b0;
    #1;
    chk("rrmw_we1", {31'b0, RAMWriteControl}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rrmw_we0", {31'b0, RAMWriteControl}, 32'h0);
    chk("rrmw_addr", RAMAddr, 32'h0);
    chk("rrmw_drvalid", {31'b0, dRValid}, 32'h0);
    chk("rrmw_irdata", iRData, 32'h0);
    chk("rrmw_drdata", dRData, 32'h0);
    tick();
    chk("rrmw_mem", mem[32'h100 >> 2], 32'h12345678);
    reset = 1'b1;
    tick();
    chk("rrmw_idle_we", {31'b0, RAMWriteControl}, 32'h0);
    iReq = 1'b1;
    dset(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    chk("post_rst_dgnt", {31'b0, dGnt}, 32'h1);
    chk("post_rst_ignt", {31'b0, iGnt}, 32'h0);
    tick(); iReq = 1'b0; dReq = 1'b0;
    chk("post_rst_data", dRData, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
